rgb_pwm_driver: RTL and testbench

//  CH-channel LED driver and successor to the fixed-rate blinker on the RGB0..RGB2 pins.

---
 rtl/rgb_pwm_driver_pkg.sv | 17 +
 rtl/rgb_pwm_driver_if.sv | 20 ++
 rtl/rgb_pwm_driver_channel.sv | 106 ++++++++++
 rtl/rgb_pwm_driver.sv | 91 +++++++++
 tb/tb_rgb_pwm_driver.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rgb_pwm_driver_pkg.sv
// Shared definitions for the RGB PWM LED driver: channel modes and a
// helper that sizes the channel-select field.
package rgb_pwm_driver_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_SOLID   = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_BREATHE = 2'b11
  } mode_e;

  // Width of a field able to address ch channels; never narrower than one bit.
  function automatic int chw(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

endpackage

// File: rtl/rgb_pwm_driver_if.sv
// Configuration port of the RGB PWM LED driver: a single-cycle write strobe
// carrying the target channel, its mode and its duty.
interface rgb_pwm_driver_if
  import rgb_pwm_driver_pkg::*;
#(
  parameter int CH    = 3,
  parameter int PWM_W = 8
);

  localparam int CHW = chw(CH);

  logic             cfg_we;
  logic [CHW-1:0]   cfg_ch;
  logic [1:0]       cfg_mode;
  logic [PWM_W-1:0] cfg_duty;

  modport master (output cfg_we, cfg_ch, cfg_mode, cfg_duty);
  modport slave  (input  cfg_we, cfg_ch, cfg_mode, cfg_duty);

endinterface

// File: rtl/rgb_pwm_driver_channel.sv
// One LED channel: shadow and active configuration, breathe ramp, duty
// compare against the shared PWM counter, and the registered pin drive.
module rgb_pwm_driver_channel
  import rgb_pwm_driver_pkg::*;
#(
  parameter int PWM_W        = 8,
  parameter int BREATHE_STEP = 1,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [1:0]       wr_mode,
  input  logic [PWM_W-1:0] wr_duty,
  input  logic             boundary,
  input  logic             blink_on,
  input  logic [PWM_W-1:0] pwm_cnt,
  output logic             led
);

  localparam logic             AL   = (ACTIVE_LOW != 0);
  localparam logic [PWM_W:0]   STEP = (PWM_W + 1)'(BREATHE_STEP);

  mode_e            shadow_mode, active_mode, next_mode;
  logic [PWM_W-1:0] shadow_duty, active_duty, next_duty;
  logic [PWM_W:0]   ramp, ramp_next, duty_ext;
  logic             dir_up, dir_next;
  logic [PWM_W-1:0] eff;
  logic             lit;

  // Configuration that becomes active at a boundary; a write in that same cycle bypasses the shadow.
  always_comb begin
    next_mode = shadow_mode;
    next_duty = shadow_duty;
    if (wr) begin
      next_mode = mode_e'(wr_mode);
      next_duty = wr_duty;
    end
    duty_ext = {1'b0, next_duty};
  end

  // Breathe ramp step taken at each boundary; a fresh BREATHE restarts from zero, a lowered peak clamps.
  always_comb begin
    ramp_next = ramp;
    dir_next  = dir_up;
    if (next_mode != MODE_BREATHE || active_mode != MODE_BREATHE) begin
      ramp_next = '0;
      dir_next  = 1'b1;
    end else if (duty_ext < ramp) begin
      ramp_next = duty_ext;
      dir_next  = 1'b0;
    end else if (dir_up) begin
      if (ramp + STEP >= duty_ext) begin
        ramp_next = duty_ext;
        dir_next  = 1'b0;
      end else begin
        ramp_next = ramp + STEP;
      end
    end else begin
      if (ramp <= STEP) begin
        ramp_next = '0;
        dir_next  = 1'b1;
      end else begin
        ramp_next = ramp - STEP;
      end
    end
  end

  // Effective duty for the current period and the compare against the timebase.
  always_comb begin
    eff = '0;
    case (active_mode)
      MODE_SOLID:   eff = active_duty;
      MODE_BLINK:   eff = blink_on ? active_duty : '0;
      MODE_BREATHE: eff = ramp[PWM_W-1:0];
      default:      eff = '0;
    endcase
    lit = (pwm_cnt < eff);
  end

  // Register configuration, ramp state and the pin drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_mode <= MODE_OFF;
      shadow_duty <= '0;
      active_mode <= MODE_OFF;
      active_duty <= '0;
      ramp        <= '0;
      dir_up      <= 1'b1;
      led         <= AL;
    end else begin
      if (wr) begin
        shadow_mode <= mode_e'(wr_mode);
        shadow_duty <= wr_duty;
      end
      if (boundary) begin
        active_mode <= next_mode;
        active_duty <= next_duty;
        ramp        <= ramp_next;
        dir_up      <= dir_next;
      end
      led <= lit ^ AL;
    end
  end

endmodule

// File: rtl/rgb_pwm_driver.sv
// Multi-channel LED PWM driver: shared prescaler and PWM timebase, period
// boundary detection, blink phase, and config write decode feeding one
// channel instance per LED pin.
module rgb_pwm_driver
  import rgb_pwm_driver_pkg::*;
#(
  parameter int CH            = 3,
  parameter int PWM_W         = 8,
  parameter int PRESCALE      = 4,
  parameter int BLINK_PERIODS = 64,
  parameter int BREATHE_STEP  = 1,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  rgb_pwm_driver_if.slave cfg,
  output logic [CH-1:0]  led,
  output logic           period_tick
);

  localparam int CHW   = chw(CH);
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BLK_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;

  logic [PRE_W-1:0] pre_cnt;
  logic [PWM_W-1:0] pwm_cnt;
  logic [BLK_W-1:0] blink_cnt;
  logic             blink_on;
  logic             tick;
  logic             boundary;
  logic [CH-1:0]    wr_sel;

  assign tick        = (pre_cnt == PRE_W'(PRESCALE - 1));
  assign boundary    = tick && (pwm_cnt == '1);
  assign period_tick = boundary;

  // Prescaler and PWM counter; the counter wraps naturally at 2**PWM_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      if (tick) begin
        pwm_cnt <= pwm_cnt + 1'b1;
      end
    end
  end

  // Blink phase shared by all channels, toggled every BLINK_PERIODS periods.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (boundary) begin
      if (blink_cnt == BLK_W'(BLINK_PERIODS - 1)) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Channel select decode; selects beyond the last channel match nothing.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < CH; i++) begin
      wr_sel[i] = cfg.cfg_we && (cfg.cfg_ch == CHW'(i));
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_ch
    rgb_pwm_driver_channel #(
      .PWM_W        (PWM_W),
      .BREATHE_STEP (BREATHE_STEP),
      .ACTIVE_LOW   (ACTIVE_LOW)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr       (wr_sel[g]),
      .wr_mode  (cfg.cfg_mode),
      .wr_duty  (cfg.cfg_duty),
      .boundary (boundary),
      .blink_on (blink_on),
      .pwm_cnt  (pwm_cnt),
      .led      (led[g])
    );
  end

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Bench for rgb_pwm_driver: a cycle-indexed behavioural model predicts led
// and period_tick every cycle, directed scenarios pin per-period lit counts,
// and a second instance with a slower prescaler checks period spacing.
module tb_rgb_pwm_driver;

  localparam int CH   = 3;
  localparam int PWM_W = 4;
  localparam int N    = 16;
  localparam int PRE  = 1;
  localparam int PRE2 = 3;
  localparam int BP   = 2;
  localparam int STEP = 1;
  localparam int AL   = 1;
  localparam int PN   = PRE * N;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] led, led2;
  logic          period_tick, period_tick2;

  always #5 clk = ~clk;

  rgb_pwm_driver_if #(.CH(CH), .PWM_W(PWM_W)) bus ();

  rgb_pwm_driver #(
    .CH(CH), .PWM_W(PWM_W), .PRESCALE(PRE), .BLINK_PERIODS(BP),
    .BREATHE_STEP(STEP), .ACTIVE_LOW(AL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg(bus), .led(led), .period_tick(period_tick)
  );

  rgb_pwm_driver #(
    .CH(CH), .PWM_W(PWM_W), .PRESCALE(PRE2), .BLINK_PERIODS(BP),
    .BREATHE_STEP(STEP), .ACTIVE_LOW(AL)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .cfg(bus), .led(led2), .period_tick(period_tick2)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit model_on = 1'b0;

  // Model state: k is the index of the current cycle since reset release.
  int k = 0;
  int pend_mode [CH];
  int pend_duty [CH];
  int act_mode  [CH];
  int ramp      [CH];
  bit up        [CH];
  int eff       [CH];
  logic [CH-1:0] exp_led;

  int cnt [16][CH];
  int cyc2 = 0;
  int last2 = -1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit we, input int ch, input int mode, input int duty);
    bus.cfg_we   = we;
    bus.cfg_ch   = 2'(ch);
    bus.cfg_mode = 2'(mode);
    bus.cfg_duty = 4'(duty);
  endtask

  // Called at a negedge; holds the strobe for exactly one rising edge.
  task automatic writeCfg(input int ch, input int mode, input int duty);
    applyStimulus(1'b1, ch, mode, duty);
    @(negedge clk);
    applyStimulus(1'b0, 0, 0, 0);
  endtask

  task automatic modelReset();
    k = 0;
    for (int i = 0; i < CH; i++) begin
      pend_mode[i] = 0; pend_duty[i] = 0; act_mode[i] = 0;
      ramp[i] = 0; up[i] = 1'b1; eff[i] = 0;
    end
    exp_led = {CH{1'b1}};
  endtask

  // One rising edge: led shows this cycle's compare, writes land in the
  // pending config, and the last cycle of a period applies it to the next.
  task automatic modelStep();
    int pwm;
    int nper;
    bit bon;
    pwm = (k / PRE) % N;
    for (int i = 0; i < CH; i++) exp_led[i] = (pwm < eff[i]) ? 1'b0 : 1'b1;
    if (bus.cfg_we === 1'b1 && int'(bus.cfg_ch) < CH) begin
      pend_mode[bus.cfg_ch] = int'(bus.cfg_mode);
      pend_duty[bus.cfg_ch] = int'(bus.cfg_duty);
    end
    if ((k % PN) == PN - 1) begin
      nper = k / PN + 1;
      bon  = ((nper / BP) % 2) == 0;
      for (int i = 0; i < CH; i++) begin
        if (pend_mode[i] == 3) begin
          if (act_mode[i] != 3) begin ramp[i] = 0; up[i] = 1'b1; end
          else if (pend_duty[i] < ramp[i]) begin ramp[i] = pend_duty[i]; up[i] = 1'b0; end
          else if (up[i]) begin
            if (ramp[i] + STEP >= pend_duty[i]) begin ramp[i] = pend_duty[i]; up[i] = 1'b0; end
            else ramp[i] = ramp[i] + STEP;
          end else begin
            if (ramp[i] <= STEP) begin ramp[i] = 0; up[i] = 1'b1; end
            else ramp[i] = ramp[i] - STEP;
          end
        end
        act_mode[i] = pend_mode[i];
        case (act_mode[i])
          1: eff[i] = pend_duty[i];
          2: eff[i] = bon ? pend_duty[i] : 0;
          3: eff[i] = ramp[i];
          default: eff[i] = 0;
        endcase
      end
    end
    k++;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) modelReset();
    else modelStep();
  end

  // Per-cycle comparison of both outputs against the model.
  initial forever begin
    @(negedge clk);
    if (model_on) begin
      checkOutput("led", led, exp_led);
      checkOutput("period_tick", period_tick, (rst_n && (k % PN) == PN - 1) ? 1 : 0);
    end
  end

  // Period spacing of the slower instance.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      cyc2 = 0; last2 = -1;
    end else begin
      cyc2++;
      if (period_tick2 === 1'b1) begin
        if (last2 >= 0) checkOutput("tick_spacing_p3", cyc2 - last2, PRE2 * N);
        else checkOutput("first_tick_p3", cyc2, PRE2 * N - 1);
        last2 = cyc2;
      end
    end
  end

  task automatic waitTick();
    int w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (period_tick !== 1'b1 && w < 100);
    checkOutput("tick_seen", period_tick, 1);
  endtask

  // Counts lit cycles (pins are active-low) per channel over whole periods.
  task automatic measure(input int nper, input bit align);
    if (align) begin
      waitTick();
      @(negedge clk);
    end
    for (int p = 0; p < nper; p++) begin
      for (int i = 0; i < CH; i++) cnt[p][i] = 0;
      for (int c = 0; c < N; c++) begin
        @(negedge clk);
        for (int i = 0; i < CH; i++) if (led[i] === 1'b0) cnt[p][i]++;
      end
    end
  endtask

  initial begin
    int br1 [8];
    int br2 [4];
    int r;
    int duty;
    br1 = '{0, 1, 2, 3, 2, 1, 0, 1};
    br2 = '{1, 0, 1, 0};
    applyStimulus(1'b0, 0, 0, 0);
    modelReset();
    repeat (3) @(negedge clk);
    model_on = 1'b1;
    checkOutput("reset_led_init", led, 7);
    checkOutput("reset_tick_init", period_tick, 0);
    #2 rst_n = 1'b1;

    // SOLID ch0 duty 4
    @(negedge clk);
    writeCfg(0, 1, 4);
    measure(1, 1);
    checkOutput("solid4_ch0", cnt[0][0], 4);

    // Mid-period write to ch1 waits for the boundary; ch 3 is ignored
    repeat (5) @(negedge clk);
    writeCfg(1, 1, 15);
    checkOutput("ch1_not_yet", led[1], 1);
    writeCfg(3, 1, 15);
    measure(1, 1);
    checkOutput("solid15_ch1", cnt[0][1], 15);
    checkOutput("solid4_ch0_again", cnt[0][0], 4);
    checkOutput("ch3_ignored_ch2", cnt[0][2], 0);

    // BLINK on ch1 and ch2, same phase
    writeCfg(2, 2, 8);
    writeCfg(1, 2, 8);
    measure(4, 1);
    for (int p = 0; p < 4; p++) begin
      checkOutput("blink_level", (cnt[p][2] == 0 || cnt[p][2] == 8) ? 1 : 0, 1);
      checkOutput("blink_phase", cnt[p][1], cnt[p][2]);
    end
    for (int p = 0; p < 2; p++) checkOutput("blink_alt", cnt[p][2] + cnt[p + 2][2], 8);

    // BREATHE ch0 duty 3, then lowered peak while ramp is at 3
    writeCfg(0, 3, 3);
    measure(8, 1);
    for (int p = 0; p < 8; p++) checkOutput("breathe3", cnt[p][0], br1[p]);
    measure(1, 0);
    checkOutput("breathe3_p8", cnt[0][0], 2);
    writeCfg(0, 3, 1);
    measure(4, 1);
    for (int p = 0; p < 4; p++) checkOutput("breathe1", cnt[p][0], br2[p]);

    // Write on the boundary cycle takes effect in the very next period
    waitTick();
    applyStimulus(1'b1, 0, 1, 11);
    @(negedge clk);
    applyStimulus(1'b0, 0, 0, 0);
    measure(1, 0);
    checkOutput("boundary_bypass", cnt[0][0], 11);

    // Randomized config traffic
    repeat (800) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) begin
        r = $urandom_range(0, 3);
        duty = (r == 0) ? 0 : (r == 1) ? 15 : int'($urandom_range(0, 15));
        applyStimulus(1'b1, $urandom_range(0, 3), $urandom_range(0, 3), duty);
      end else begin
        applyStimulus(1'b0, 0, 0, 0);
      end
    end
    @(negedge clk);
    applyStimulus(1'b0, 0, 0, 0);

    // Reset in the middle of a lit SOLID period
    writeCfg(0, 1, 8);
    measure(1, 1);
    waitTick();
    repeat (2) @(negedge clk);
    checkOutput("pre_reset_lit", led[0], 0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_led_async", led, 7);
    checkOutput("reset_led_async_p3", led2, 7);
    checkOutput("reset_tick_async", period_tick, 0);
    repeat (4) begin
      @(negedge clk);
      checkOutput("reset_held", led, 7);
    end
    #2 rst_n = 1'b1;
    measure(2, 1);
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < CH; i++) checkOutput("dark_after_reset", cnt[p][i], 0);
    repeat (60) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
